// File: rtl/dqn_fixed_pkg.sv
// ---------------------------------------------------------------------------
// dqn_fixed_pkg
// Shared Q6.10 fixed-point definitions for the DQN datapath blocks
// (dw_module, weight_update_unit, MAC blocks).
//   WORD_W / FRAC_W : word and fraction widths of the Q6.10 format
//   Q_MAX / Q_MIN   : most positive / most negative representable word
//   q6_10_t         : signed 16-bit Q6.10 word
//   sat16()         : clamps a 17-bit signed intermediate into a q6_10_t
// ---------------------------------------------------------------------------
package dqn_fixed_pkg;

  localparam int          WORD_W = 16;
  localparam int          FRAC_W = 10;
  localparam logic [15:0] Q_MAX  = 16'h7FFF;
  localparam logic [15:0] Q_MIN  = 16'h8000;

  typedef logic signed [WORD_W-1:0] q6_10_t;

  // A 17-bit sum/difference of two 16-bit words has overflowed exactly when
  // its top two bits disagree; the top bit then gives the true sign.
  function automatic q6_10_t sat16(input logic [WORD_W:0] x);
    q6_10_t r;
    if (x[WORD_W] != x[WORD_W-1]) begin
      r = x[WORD_W] ? q6_10_t'(Q_MIN) : q6_10_t'(Q_MAX);
    end else begin
      r = q6_10_t'(x[WORD_W-1:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/q_sat_sub.sv
// ---------------------------------------------------------------------------
// q_sat_sub
// Combinational saturating subtract of two Q6.10 words: diff = sat(a - b).
// Ports:
//   a    in  16  minuend, signed Q6.10
//   b    in  16  subtrahend, signed Q6.10
//   diff out 16  a - b clamped to [0x8000, 0x7FFF]
//   sat  out 1   high when the clamp was applied
// ---------------------------------------------------------------------------
module q_sat_sub
  import dqn_fixed_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] diff,
  output logic              sat
);

  logic [WORD_W:0] wide;

  // Sign-extend both operands to 17 bits so the difference cannot wrap.
  assign wide = {a[WORD_W-1], a} - {b[WORD_W-1], b};
  assign diff = sat16(wide);
  assign sat  = wide[WORD_W] ^ wide[WORD_W-1];

endmodule

// File: rtl/weight_update_unit.sv
// ---------------------------------------------------------------------------
// weight_update_unit
// Holds a layer's Q6.10 weight register file and applies gradient updates
//   w[addr] <= sat(w[addr] - (dw >>> LR_SHIFT))
// through a two-stage pipeline (accept, then read-modify-write).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   init_en    load init_data into w[init_addr] this cycle
//   init_addr  init write address
//   init_data  init weight, signed Q6.10
//   upd_valid  update request valid
//   upd_ready  unit can accept an update this cycle (low during init)
//   upd_addr   weight index to update
//   upd_dw     signed Q6.10 gradient
//   rd_addr    forward-pass read address
//   rd_data    w[rd_addr], registered, 1-cycle latency
//   busy       an accepted update is still waiting to be written
//   sat_flag   sticky: some update saturated since reset
//   upd_cnt    count of completed updates, wraps
// ---------------------------------------------------------------------------
module weight_update_unit
  import dqn_fixed_pkg::*;
#(
  parameter int N_WEIGHTS = 16,
  parameter int AW        = 4,
  parameter int LR_SHIFT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_en,
  input  logic [AW-1:0]     init_addr,
  input  logic [WORD_W-1:0] init_data,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [AW-1:0]     upd_addr,
  input  logic [WORD_W-1:0] upd_dw,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              sat_flag,
  output logic [15:0]       upd_cnt
);

  q6_10_t        w [N_WEIGHTS];

  logic          p_vld;
  logic [AW-1:0] p_addr;
  q6_10_t        p_step;

  logic          accept;
  q6_10_t        new_w;
  logic          new_sat;

  // Init port owns the write slot, so updates are held off while it is active.
  assign upd_ready = ~init_en;
  assign accept    = upd_valid & upd_ready;
  assign busy      = p_vld;

  // The learning-rate scale happens at accept time so stage 2 is a plain
  // saturating subtract; the arithmetic shift rounds toward -inf.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld  <= 1'b0;
      p_addr <= '0;
      p_step <= '0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p_addr <= upd_addr;
        p_step <= q6_10_t'($signed(upd_dw) >>> LR_SHIFT);
      end
    end
  end

  // Stage 2 reads the array directly; a back-to-back update to the same
  // address sees the previous write because that write landed on the edge
  // that accepted the second update.
  q_sat_sub u_sub (
    .a    (w[p_addr]),
    .b    (p_step),
    .diff (new_w),
    .sat  (new_sat)
  );

  // Weight array: the init write is placed last so it overrides a stage-2
  // write to the same address on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WEIGHTS; i++) begin
        w[i] <= '0;
      end
    end else begin
      if (p_vld) begin
        w[p_addr] <= new_w;
      end
      if (init_en) begin
        w[init_addr] <= q6_10_t'(init_data);
      end
    end
  end

  // Completion bookkeeping: the counter and sticky flag follow stage 2 even
  // when an init write overrides the stored result.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (p_vld) begin
      upd_cnt <= upd_cnt + 16'd1;
      if (new_sat) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // Read port samples the array before this edge's writes take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= w[rd_addr];
    end
  end

endmodule

// File: tb/tb_weight_update_unit.sv
// ---------------------------------------------------------------------------
// tb_weight_update_unit
// Directed bench for weight_update_unit with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_weight_update_unit;

  logic        clk;
  logic        rst;
  logic        init_en;
  logic [3:0]  init_addr;
  logic [15:0] init_data;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_addr;
  logic [15:0] upd_dw;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        sat_flag;
  logic [15:0] upd_cnt;

  int vectors;
  int miscompares;

  weight_update_unit #(
    .N_WEIGHTS (16),
    .AW        (4),
    .LR_SHIFT  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_en   (init_en),
    .init_addr (init_addr),
    .init_data (init_data),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_addr  (upd_addr),
    .upd_dw    (upd_dw),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .upd_cnt   (upd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic initWrite(input logic [3:0] a, input logic [15:0] d);
    init_en   = 1'b1;
    init_addr = a;
    init_data = d;
    tick();
    init_en   = 1'b0;
  endtask

  // One accepted update (init_en is low, so it is taken on the next edge).
  task automatic applyStimulus(input logic [3:0] a, input logic [15:0] dw);
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_dw    = dw;
    tick();
    upd_valid = 1'b0;
  endtask

  // Two edges: the first lets any pending write land, the second samples it.
  task automatic readWeight(input logic [3:0] a, output logic [15:0] d);
    rd_addr = a;
    tick();
    tick();
    d = rd_data;
  endtask

  logic [15:0] rd;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    init_en   = 1'b0;
    init_addr = '0;
    init_data = '0;
    upd_valid = 1'b0;
    upd_addr  = '0;
    upd_dw    = '0;
    rd_addr   = '0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sat", 32'(sat_flag), 32'd0);
    checkOutput("rst_cnt", 32'(upd_cnt), 32'd0);
    checkOutput("rst_rd", 32'(rd_data), 32'd0);
    checkOutput("rst_ready", 32'(upd_ready), 32'd1);

    $display("[TB] basic update");
    initWrite(4'd2, 16'h0400);
    applyStimulus(4'd2, 16'h0800);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    readWeight(4'd2, rd);
    checkOutput("t1_w2", 32'(rd), 32'h0300);
    checkOutput("t1_cnt", 32'(upd_cnt), 32'd1);
    checkOutput("t1_sat", 32'(sat_flag), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    $display("[TB] negative dw");
    initWrite(4'd5, 16'h0000);
    applyStimulus(4'd5, 16'hF800);
    readWeight(4'd5, rd);
    checkOutput("t2_w5", 32'(rd), 32'h0100);
    checkOutput("t2_cnt", 32'(upd_cnt), 32'd2);

    $display("[TB] saturation");
    initWrite(4'd1, 16'h8010);
    applyStimulus(4'd1, 16'h0400);
    readWeight(4'd1, rd);
    checkOutput("t3_w1", 32'(rd), 32'h8000);
    checkOutput("t3_sat", 32'(sat_flag), 32'd1);

    $display("[TB] back-to-back same address");
    initWrite(4'd3, 16'h0400);
    upd_valid = 1'b1;
    upd_addr  = 4'd3;
    upd_dw    = 16'h0800;
    tick();
    checkOutput("t4_busy_a", 32'(busy), 32'd1);
    tick();
    upd_valid = 1'b0;
    checkOutput("t4_busy_b", 32'(busy), 32'd1);
    tick();
    checkOutput("t4_busy_c", 32'(busy), 32'd0);
    readWeight(4'd3, rd);
    checkOutput("t4_w3", 32'(rd), 32'h0200);
    checkOutput("t4_cnt", 32'(upd_cnt), 32'd5);
    checkOutput("t4_sat_sticky", 32'(sat_flag), 32'd1);

    $display("[TB] init collision and held request");
    applyStimulus(4'd7, 16'h0400);
    upd_valid = 1'b1;
    upd_addr  = 4'd9;
    upd_dw    = 16'h0800;
    init_en   = 1'b1;
    init_addr = 4'd7;
    init_data = 16'h1234;
    #1;
    checkOutput("t5_ready", 32'(upd_ready), 32'd0);
    tick();
    init_en   = 1'b0;
    upd_valid = 1'b0;
    checkOutput("t5_not_taken", 32'(busy), 32'd0);
    checkOutput("t5_cnt", 32'(upd_cnt), 32'd6);
    readWeight(4'd7, rd);
    checkOutput("t5_w7", 32'(rd), 32'h1234);
    readWeight(4'd9, rd);
    checkOutput("t5_w9", 32'(rd), 32'h0000);

    $display("[TB] init and update to different addresses");
    applyStimulus(4'd2, 16'h0800);
    initWrite(4'd4, 16'h0ABC);
    readWeight(4'd2, rd);
    checkOutput("t5b_w2", 32'(rd), 32'h0200);
    readWeight(4'd4, rd);
    checkOutput("t5b_w4", 32'(rd), 32'h0ABC);
    checkOutput("t5b_cnt", 32'(upd_cnt), 32'd7);

    $display("[TB] reset mid-operation");
    rd_addr = 4'd4;
    applyStimulus(4'd2, 16'h0800);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_cnt", 32'(upd_cnt), 32'd0);
    checkOutput("t6_sat", 32'(sat_flag), 32'd0);
    checkOutput("t6_rd", 32'(rd_data), 32'd0);
    readWeight(4'd2, rd);
    checkOutput("t6_w2", 32'(rd), 32'h0000);
    readWeight(4'd4, rd);
    checkOutput("t6_w4", 32'(rd), 32'h0000);
    readWeight(4'd7, rd);
    checkOutput("t6_w7", 32'(rd), 32'h0000);
    checkOutput("t6_cnt_after", 32'(upd_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
